test_edge_sync: RTL and testbench



---
 rtl/test_edge_sync.sv | 57 +++++
 tb/tb_test_edge_sync.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_edge_sync.sv
// test_edge_sync: single-bit input conditioner.
// Brings the asynchronous level `a` into the clk domain through a flop
// chain, presents the clean level on `b`, and produces one-cycle rise/fall
// strobes (`c`/`d`) plus a toggle flag (`e`) that flips on every rise.
// All outputs are flop outputs, so `a` has no combinational path to them.
module test_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e
);

    // Depths below 2 would leave no flop to look ahead at, so clamp to 2.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // sync[0] is the metastability-catching flop; sync[STAGES-1] drives b.
    logic [STAGES-1:0] sync;

    // Level that b will take on the next edge; comparing it with the
    // current b lets the strobes land on the same edge that b changes.
    logic nxt;
    logic rise;
    logic fall;

    assign nxt  = sync[STAGES-2];
    assign rise = nxt & ~b;
    assign fall = ~nxt & b;
    assign b    = sync[STAGES-1];

    // Synchronizer chain: shift a in at stage 0, clear everything on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], a};
        end
    end

    // Edge strobes and toggle flag, registered alongside the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
            d <= 1'b0;
            e <= 1'b0;
        end else begin
            c <= rise;
            d <= fall;
            e <= e ^ rise;
        end
    end

endmodule

// File: tb/tb_test_edge_sync.sv
// tb_test_edge_sync: drives two instances (default depth and depth 3) with
// directed and randomized stimulus and compares every cycle against a
// behavioural model built from sample history and a rise counter.
module tb_test_edge_sync;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic a;
    logic b2, c2, d2, e2;
    logic b3, c3, d3, e3;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    test_edge_sync dut2 (
        .clk(clk), .rst(rst), .a(a),
        .b(b2), .c(c2), .d(d2), .e(e2)
    );

    test_edge_sync #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .a(a),
        .b(b3), .c(c3), .d(d3), .e(e3)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[0] is the a value sampled at the latest edge, hist[k] the one k
    // edges earlier; reset wipes the history. b is the sample taken
    // (depth-1) edges ago, strobes are the transitions of that level, and
    // e is the parity of the number of rises seen since reset.
    typedef struct {
        logic [7:0] hist;
        logic       b;
        logic       c;
        logic       d;
        int         rises;
    } model_t;

    function automatic model_t step(input model_t m, input int depth,
                                    input logic a_s, input logic r);
        model_t n;
        logic   new_b;
        n = m;
        if (r) begin
            n.hist  = '0;
            n.b     = 1'b0;
            n.c     = 1'b0;
            n.d     = 1'b0;
            n.rises = 0;
        end else begin
            n.hist  = {m.hist[6:0], a_s};
            new_b   = n.hist[depth-1];
            n.c     = new_b & ~m.b;
            n.d     = ~new_b & m.b;
            n.rises = m.rises + (n.c ? 1 : 0);
            n.b     = new_b;
        end
        return n;
    endfunction

    model_t m2 = '{hist: '0, b: 1'b0, c: 1'b0, d: 1'b0, rises: 0};
    model_t m3 = '{hist: '0, b: 1'b0, c: 1'b0, d: 1'b0, rises: 0};
    bit model_live = 1'b0;

    // Advance both models on every rising edge from the same sampled inputs.
    always @(posedge clk) begin
        m2 = step(m2, 2, a, rst);
        m3 = step(m3, 3, a, rst);
        if (rst) model_live = 1'b1;
    end

    // Compare process: check every output of both instances each cycle.
    always @(negedge clk) begin
        if (model_live) begin
            chk("cmp2_b", b2, m2.b);
            chk("cmp2_c", c2, m2.c);
            chk("cmp2_d", d2, m2.d);
            chk("cmp2_e", e2, m2.rises[0]);
            chk("cmp3_b", b3, m3.b);
            chk("cmp3_c", c3, m3.c);
            chk("cmp3_d", d3, m3.d);
            chk("cmp3_e", e3, m3.rises[0]);
            chk("cmp2_cd_excl", c2 & d2, 1'b0);
        end
    end

    // Strobe counters for the pinned directed checks.
    int c2_cnt = 0;
    int d2_cnt = 0;
    always @(negedge clk) begin
        if (c2 === 1'b1) c2_cnt++;
        if (d2 === 1'b1) d2_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    int c_base;
    int d_base;

    initial begin
        rst = 1'b1;
        a   = 1'b0;

        // Reset: three cycles, then five idle cycles with all outputs low.
        idle(3);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            after_edge();
            chk("rst_b", b2, 1'b0);
            chk("rst_c", c2, 1'b0);
            chk("rst_d", d2, 1'b0);
            chk("rst_e", e2, 1'b0);
        end

        // Single rise, changed midway between edges.
        @(negedge clk);
        a = 1'b1;
        after_edge();
        chk("rise2_b_e1", b2, 1'b0);
        after_edge();
        chk("rise2_b_e2", b2, 1'b1);
        chk("rise2_c_e2", c2, 1'b1);
        chk("rise2_e_e2", e2, 1'b1);
        chk("rise3_b_e2", b3, 1'b0);
        after_edge();
        chk("rise2_c_e3", c2, 1'b0);
        chk("rise3_b_e3", b3, 1'b1);
        chk("rise3_c_e3", c3, 1'b1);
        idle(10);

        // Single fall.
        @(negedge clk);
        a = 1'b0;
        after_edge();
        chk("fall2_b_e1", b2, 1'b1);
        after_edge();
        chk("fall2_b_e2", b2, 1'b0);
        chk("fall2_d_e2", d2, 1'b1);
        chk("fall2_c_e2", c2, 1'b0);
        chk("fall2_e_e2", e2, 1'b1);
        idle(5);

        // Pulse train: three rises and two falls.
        c_base = c2_cnt;
        d_base = d2_cnt;
        @(negedge clk); a = 1'b1;
        idle(3);        a = 1'b0;
        idle(2);        a = 1'b1;
        idle(4);        a = 1'b0;
        idle(3);        a = 1'b1;
        idle(6);
        chk_int("train_c_count", c2_cnt - c_base, 3);
        chk_int("train_d_count", d2_cnt - d_base, 2);
        chk("train_e_final", e2, 1'b0);
        chk("train_b_final", b2, 1'b1);

        // Reset mid-flight: rise captured, then reset before it reaches b.
        a = 1'b0;
        idle(6);
        c_base = c2_cnt;
        a = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_e", e2, 1'b0);
        chk("midrst_b", b2, 1'b0);
        chk_int("midrst_no_c", c2_cnt - c_base, 0);
        idle(4);
        chk_int("midrst_c_after", c2_cnt - c_base, 1);
        chk("midrst_e_after", e2, 1'b1);
        chk("midrst_e3_after", e3, 1'b1);

        // Randomized: arbitrary phase, sub-cycle glitches, occasional reset.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 29) == 0);
            #($urandom_range(1, 7));
            a = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                #1;
                a = ~a;
            end
        end
        rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
